// File: rtl/video_frame_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : video_frame_buffer_arbiter
// Description : Arbitrates whole bursts from the frame reader and frame writer
//               onto one memory command port. The reader has priority, and one
//               burst is outstanding at a time. Define FB_ARB_STARVE_GUARD_EN
//               to force a writer turn after STARVE_MAX reader grants.
// Revision    : 1.0 - initial release
// ============================================================================
module video_frame_buffer_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int LEN_W      = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_gnt,
    output logic              rd_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    output logic              wr_gnt,
    output logic              wr_done,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_wr,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [LEN_W-1:0]  mem_cmd_len,
    input  logic              mem_done,
    output logic              busy
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_BUSY  = 2'd2;

    logic [1:0] r_state;
    logic       w_accept;
    logic       w_pick_wr;

    // mem_cmd_wr doubles as the owner of the current/most recent burst
    assign w_accept = (r_state == c_ST_ISSUE) && mem_cmd_valid && mem_cmd_ready;
    assign rd_gnt   = w_accept && !mem_cmd_wr;
    assign wr_gnt   = w_accept && mem_cmd_wr;
    assign busy     = (r_state != c_ST_IDLE);

`ifdef FB_ARB_STARVE_GUARD_EN
    localparam int                    c_STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_LIM = c_STARVE_W'(STARVE_MAX);

    logic [c_STARVE_W-1:0] r_starve_cnt;

    assign w_pick_wr = wr_req && (!rd_req || (r_starve_cnt == c_STARVE_LIM));

    // Counts reader grants taken while the writer was waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_accept) begin
            if (mem_cmd_wr || !wr_req) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != c_STARVE_LIM) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end
`else
    assign w_pick_wr = wr_req && !rd_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            mem_cmd_valid <= 1'b0;
            mem_cmd_wr    <= 1'b0;
            mem_cmd_addr  <= '0;
            mem_cmd_len   <= '0;
            rd_done       <= 1'b0;
            wr_done       <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            wr_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (rd_req || wr_req) begin
                        mem_cmd_valid <= 1'b1;
                        mem_cmd_wr    <= w_pick_wr;
                        mem_cmd_addr  <= w_pick_wr ? wr_addr : rd_addr;
                        mem_cmd_len   <= w_pick_wr ? wr_len : rd_len;
                        r_state       <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    if (mem_cmd_ready) begin
                        mem_cmd_valid <= 1'b0;
                        r_state       <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    if (mem_done) begin
                        rd_done <= !mem_cmd_wr;
                        wr_done <= mem_cmd_wr;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    mem_cmd_valid <= 1'b0;
                    r_state       <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
